pll_lock_sequencer: RTL

Power-up and recovery sequencer for the camera clock PLL that produces the 24 MHz camera XCLK from the 50 MHz reference. It runs on the reference clock, pulses the PLL reset and qualifies the PLL lock with a debounce window. Only after a stable lock does it release the XCLK output enable and step the camera power-down and reset pins. It also retries failed locks, re-sequences on loss of lock, and accepts a software restart from the HPS register block.

---
 rtl/pll_lock_sequencer_if.sv | 20 ++
 rtl/pll_lock_sequencer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer_if.sv
// pll_lock_sequencer_if: PLL lock input, software restart and camera/PLL control outputs of the lock sequencer
interface pll_lock_sequencer_if;
    logic       pll_locked;
    logic       restart;
    logic       pll_rst;
    logic       clk_en;
    logic       cam_pwdn;
    logic       cam_reset_n;
    logic       ready;
    logic       fault;
    logic [3:0] retry_count;
    modport master (
        output pll_locked, restart,
        input  pll_rst, clk_en, cam_pwdn, cam_reset_n, ready, fault, retry_count
    );
    modport slave (
        input  pll_locked, restart,
        output pll_rst, clk_en, cam_pwdn, cam_reset_n, ready, fault, retry_count
    );
endinterface

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: pulses the PLL reset, debounces lock, then releases XCLK and steps the camera out of reset
module pll_lock_sequencer #(
    parameter int RST_CYCLES          = 10,
    parameter int LOCK_STABLE_CYCLES  = 1000,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int CAM_RST_CYCLES      = 2400,
    parameter int MAX_RETRIES         = 3
) (
    input logic                 refclk,
    input logic                 rst,
    pll_lock_sequencer_if.slave bus
);
    localparam int MAX_A = RST_CYCLES > LOCK_STABLE_CYCLES ? RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int MAX_B = LOCK_TIMEOUT_CYCLES > CAM_RST_CYCLES ? LOCK_TIMEOUT_CYCLES : CAM_RST_CYCLES;
    localparam int MAX_C = MAX_A > MAX_B ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_C) + 1;
    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CAM_LAST = CW'(CAM_RST_CYCLES - 1);
    localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        PLL_RST, WAIT_LOCK, STABLE, CAM_RST, RUN, FAULT
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    retry_q, retry_d;
    logic          sync_q, lk_q;
    logic          pll_rst_q, pll_rst_d;
    logic          clk_en_q, clk_en_d;
    logic          cam_pwdn_q, cam_pwdn_d;
    logic          cam_reset_n_q, cam_reset_n_d;
    logic          ready_q, ready_d;
    logic          fault_q, fault_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        retry_d = retry_q;
        if (bus.restart) begin
            state_d = PLL_RST;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                PLL_RST: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end
                end
                WAIT_LOCK: begin
                    if (lk_q) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TO_LAST) begin
                        cnt_d   = '0;
                        state_d = retry_q == RETRY_MAX ? FAULT : PLL_RST;
                        retry_d = retry_q == RETRY_MAX ? retry_q : retry_q + 4'd1;
                    end
                end
                STABLE: begin
                    if (!lk_q) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STB_LAST) begin
                        state_d = CAM_RST;
                        cnt_d   = '0;
                    end
                end
                CAM_RST: begin
                    if (!lk_q) begin
                        state_d = PLL_RST;
                        cnt_d   = '0;
                    end else if (cnt_q == CAM_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                        retry_d = '0;
                    end
                end
                RUN: begin
                    cnt_d   = lk_q ? cnt_q : '0;
                    state_d = lk_q ? RUN : PLL_RST;
                end
                FAULT: cnt_d = cnt_q;
                default: begin
                    state_d = PLL_RST;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs decode the next state so they change on the same edge as the state itself
    always_comb begin
        pll_rst_d     = state_d == PLL_RST || state_d == FAULT;
        clk_en_d      = state_d == CAM_RST || state_d == RUN;
        cam_pwdn_d    = !clk_en_d;
        cam_reset_n_d = state_d == RUN;
        ready_d       = state_d == RUN;
        fault_d       = state_d == FAULT;
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            sync_q        <= 1'b0;
            lk_q          <= 1'b0;
            state_q       <= PLL_RST;
            cnt_q         <= '0;
            retry_q       <= '0;
            pll_rst_q     <= 1'b1;
            clk_en_q      <= 1'b0;
            cam_pwdn_q    <= 1'b1;
            cam_reset_n_q <= 1'b0;
            ready_q       <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            sync_q        <= bus.pll_locked;
            lk_q          <= sync_q;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retry_q       <= retry_d;
            pll_rst_q     <= pll_rst_d;
            clk_en_q      <= clk_en_d;
            cam_pwdn_q    <= cam_pwdn_d;
            cam_reset_n_q <= cam_reset_n_d;
            ready_q       <= ready_d;
            fault_q       <= fault_d;
        end
    end

    assign bus.pll_rst     = pll_rst_q;
    assign bus.clk_en      = clk_en_q;
    assign bus.cam_pwdn    = cam_pwdn_q;
    assign bus.cam_reset_n = cam_reset_n_q;
    assign bus.ready       = ready_q;
    assign bus.fault       = fault_q;
    assign bus.retry_count = retry_q;
endmodule
